// File: rtl/pid_mixer_seq.sv
// ---------------------------------------------------------------------------
// pid_mixer_seq
//
// Sequential PID evaluation and quad-X motor mixer. A start pulse latches
// the per-axis P/I/D error terms, the three gains, the collective throttle
// and the arm flag. Nine products then go through one shared multiplier,
// pitch P,I,D first, then roll, then yaw. Each axis sum is scaled down by
// FRAC bits with floor rounding. The three corrections are mixed onto four
// duty words, and each duty is clamped to [DUTY_MIN, DUTY_MAX] with its own
// saturation flag.
//
// Ports
//   clk          clock
//   rst_n        synchronous reset, active-low
//   start_i      request one computation (ignored unless idle)
//   arm_i        sampled with start_i; 0 forces every duty to DUTY_MIN
//   kp_i/ki_i/kd_i  unsigned gains with FRAC fraction bits, latched at start
//   pwm_base_i   collective throttle (unsigned), latched at start
//   p_err_i/i_err_i/d_err_i  signed errors {yaw,roll,pitch}, pitch in LSBs
//   busy_o       computation in progress
//   done_o       one-cycle pulse when pwm_duty_o / sat_flags_o update
//   pwm_duty_o   {duty4,duty3,duty2,duty1}, duty1 in LSBs
//   sat_flags_o  bit n-1 set when duty n was clamped
// ---------------------------------------------------------------------------
module pid_mixer_seq #(
    parameter int            DW       = 24,
    parameter int            GW       = 16,
    parameter int            FRAC     = 8,
    parameter int            OW       = 16,
    parameter logic [OW-1:0] DUTY_MIN = '0,
    parameter logic [OW-1:0] DUTY_MAX = OW'(50000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            arm_i,
    input  logic [GW-1:0]   kp_i,
    input  logic [GW-1:0]   ki_i,
    input  logic [GW-1:0]   kd_i,
    input  logic [OW-1:0]   pwm_base_i,
    input  logic [3*DW-1:0] p_err_i,
    input  logic [3*DW-1:0] i_err_i,
    input  logic [3*DW-1:0] d_err_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [4*OW-1:0] pwm_duty_o,
    output logic [3:0]      sat_flags_o
);

    localparam int PW   = DW + GW + 1;   // signed error x zero-extended gain
    localparam int ACCW = DW + GW + 4;   // headroom for three products
    localparam int MW   = ACCW + 2;      // headroom for base +/- three terms

    // Mixer sign per motor, bit n-1 = duty n; 1 means "+u", 0 means "-u".
    localparam logic [3:0] SGN_P = 4'b1100;
    localparam logic [3:0] SGN_R = 4'b1010;
    localparam logic [3:0] SGN_Y = 4'b0110;

    localparam logic signed [MW-1:0] MIN_EXT = {{(MW-OW){1'b0}}, DUTY_MIN};
    localparam logic signed [MW-1:0] MAX_EXT = {{(MW-OW){1'b0}}, DUTY_MAX};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_SCALE,
        S_MIX
    } state_t;

    state_t                 state_q;
    logic [1:0]             axis_q;
    logic [1:0]             term_q;
    logic [GW-1:0]          kp_q;
    logic [GW-1:0]          ki_q;
    logic [GW-1:0]          kd_q;
    logic [OW-1:0]          base_q;
    logic                   arm_q;
    logic [3*DW-1:0]        p_q;
    logic [3*DW-1:0]        i_q;
    logic [3*DW-1:0]        d_q;
    logic signed [ACCW-1:0] acc_q [3];
    logic signed [ACCW-1:0] u_q   [3];

    // ---------------- shared multiplier operand selection ----------------
    logic [3*DW-1:0]        term_vec;
    logic [GW-1:0]          gain_mux;
    logic signed [DW-1:0]   err_mux;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;

    always_comb begin
        term_vec = p_q;
        gain_mux = kp_q;
        case (term_q)
            2'd1: begin
                term_vec = i_q;
                gain_mux = ki_q;
            end
            2'd2: begin
                term_vec = d_q;
                gain_mux = kd_q;
            end
            default: ;
        endcase
        err_mux = term_vec[DW-1:0];
        case (axis_q)
            2'd1:    err_mux = term_vec[2*DW-1:DW];
            2'd2:    err_mux = term_vec[3*DW-1:2*DW];
            default: ;
        endcase
    end

    // Gain is unsigned: a leading zero makes it a non-negative signed operand.
    assign prod     = err_mux * $signed({1'b0, gain_mux});
    assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};

    // ---------------- mixer and clamp ----------------
    logic signed [MW-1:0] base_ext;
    logic signed [MW-1:0] u_ext [3];
    logic [4*OW-1:0]      duty_d;
    logic [3:0]           flags_d;

    assign base_ext = {{(MW-OW){1'b0}}, base_q};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_uext
            assign u_ext[gi] = {{(MW-ACCW){u_q[gi][ACCW-1]}}, u_q[gi]};
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_motor
            logic signed [MW-1:0] mix;
            logic                 lo;
            logic                 hi;

            assign mix = base_ext
                       + (SGN_P[gi] ? u_ext[0] : -u_ext[0])
                       + (SGN_R[gi] ? u_ext[1] : -u_ext[1])
                       + (SGN_Y[gi] ? u_ext[2] : -u_ext[2]);
            assign lo  = (mix < MIN_EXT);
            assign hi  = (mix > MAX_EXT);

            // Disarmed: duty pinned low and nothing reported as clamped.
            assign duty_d[gi*OW +: OW] = !arm_q ? DUTY_MIN :
                                         lo     ? DUTY_MIN :
                                         hi     ? DUTY_MAX : mix[OW-1:0];
            assign flags_d[gi] = arm_q & (lo | hi);
        end
    endgenerate

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            axis_q      <= '0;
            term_q      <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            base_q      <= '0;
            arm_q       <= 1'b0;
            p_q         <= '0;
            i_q         <= '0;
            d_q         <= '0;
            for (int a = 0; a < 3; a++) begin
                acc_q[a] <= '0;
                u_q[a]   <= '0;
            end
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pwm_duty_o  <= '0;
            sat_flags_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        kp_q   <= kp_i;
                        ki_q   <= ki_i;
                        kd_q   <= kd_i;
                        base_q <= pwm_base_i;
                        arm_q  <= arm_i;
                        p_q    <= p_err_i;
                        i_q    <= i_err_i;
                        d_q    <= d_err_i;
                        axis_q <= '0;
                        term_q <= '0;
                        for (int a = 0; a < 3; a++) begin
                            acc_q[a] <= '0;
                        end
                        busy_o  <= 1'b1;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q[axis_q] <= acc_q[axis_q] + prod_ext;
                    if (term_q == 2'd2) begin
                        term_q <= '0;
                        if (axis_q == 2'd2) begin
                            state_q <= S_SCALE;
                        end else begin
                            axis_q <= axis_q + 2'd1;
                        end
                    end else begin
                        term_q <= term_q + 2'd1;
                    end
                end
                S_SCALE: begin
                    // Arithmetic shift: floor rounding of negative sums.
                    for (int a = 0; a < 3; a++) begin
                        u_q[a] <= acc_q[a] >>> FRAC;
                    end
                    state_q <= S_MIX;
                end
                S_MIX: begin
                    pwm_duty_o  <= duty_d;
                    sat_flags_o <= flags_d;
                    done_o      <= 1'b1;
                    busy_o      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_mixer_seq.sv
// Testbench for pid_mixer_seq: directed cases from the block's usage notes
// plus randomized runs, all checked against an arithmetic reference model.
module tb_pid_mixer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        arm_i;
    logic [15:0] kp_i, ki_i, kd_i;
    logic [15:0] pwm_base_i;
    logic [71:0] p_err_i, i_err_i, d_err_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] pwm_duty_o;
    logic [3:0]  sat_flags_o;

    always #5 clk = ~clk;

    pid_mixer_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .arm_i      (arm_i),
        .kp_i       (kp_i),
        .ki_i       (ki_i),
        .kd_i       (kd_i),
        .pwm_base_i (pwm_base_i),
        .p_err_i    (p_err_i),
        .i_err_i    (i_err_i),
        .d_err_i    (d_err_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pwm_duty_o (pwm_duty_o),
        .sat_flags_o(sat_flags_o)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Current test case: index 0 pitch, 1 roll, 2 yaw.
    int pe[3], ie[3], de[3];
    int kp, ki, kd, base;
    bit arm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic set_default();
        for (int a = 0; a < 3; a++) begin
            pe[a] = 0;
            ie[a] = 0;
            de[a] = 0;
        end
        kp = 256; ki = 0; kd = 0; base = 30000; arm = 1'b1;
    endtask

    // Reference: axis sums, floor divide by 256, quad-X mix, clamp [0,50000].
    task automatic model(output logic [63:0] ed, output logic [3:0] ef);
        longint acc, u[3], d[4], dc;
        for (int a = 0; a < 3; a++) begin
            acc  = longint'(pe[a]) * kp + longint'(ie[a]) * ki + longint'(de[a]) * kd;
            u[a] = acc >>> 8;
        end
        d[0] = base - u[0] - u[1] - u[2];
        d[1] = base - u[0] + u[1] + u[2];
        d[2] = base + u[0] - u[1] + u[2];
        d[3] = base + u[0] + u[1] - u[2];
        ed = '0;
        ef = '0;
        for (int m = 0; m < 4; m++) begin
            dc = d[m];
            if (!arm) dc = 0;
            else if (d[m] < 0) begin dc = 0; ef[m] = 1'b1; end
            else if (d[m] > 50000) begin dc = 50000; ef[m] = 1'b1; end
            ed[m*16 +: 16] = 16'(dc);
        end
    endtask

    task automatic drive_case();
        p_err_i    = {24'(pe[2]), 24'(pe[1]), 24'(pe[0])};
        i_err_i    = {24'(ie[2]), 24'(ie[1]), 24'(ie[0])};
        d_err_i    = {24'(de[2]), 24'(de[1]), 24'(de[0])};
        kp_i       = 16'(kp);
        ki_i       = 16'(ki);
        kd_i       = 16'(kd);
        pwm_base_i = 16'(base);
        arm_i      = arm;
    endtask

    task automatic scramble_inputs();
        p_err_i    = {8'($urandom()), $urandom(), $urandom()};
        i_err_i    = {8'($urandom()), $urandom(), $urandom()};
        d_err_i    = {8'($urandom()), $urandom(), $urandom()};
        kp_i       = 16'($urandom());
        ki_i       = 16'($urandom());
        kd_i       = 16'($urandom());
        pwm_base_i = 16'($urandom());
        arm_i      = ~arm_i;
    endtask

    // One full transaction: start, latency, results, done pulse width.
    task automatic run_case(input string tag);
        logic [63:0] ed;
        logic [3:0]  ef;
        int          cyc;
        bit          got;
        model(ed, ef);
        @(posedge clk); #1;
        drive_case();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        scramble_inputs();
        chk({tag, "_busy_hi"}, 64'(busy_o), 64'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            got = done_o;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd11);
        chk({tag, "_duty"}, pwm_duty_o, ed);
        chk({tag, "_flags"}, 64'(sat_flags_o), 64'(ef));
        chk({tag, "_busy_lo"}, 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, 64'(done_o), 64'd0);
        $display("run %s: lat=%0d duty=%h flags=%b (exp %h %b)",
                 tag, cyc, pwm_duty_o, sat_flags_o, ed, ef);
    endtask

    initial begin
        logic [63:0] ed;
        logic [3:0]  ef;
        int          ndone, first;

        rst_n = 1'b0; start_i = 1'b0;
        set_default();
        drive_case();
        // Reset
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_duty", pwm_duty_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_flags", 64'(sat_flags_o), 64'd0);
        rst_n = 1'b1;

        // All errors zero
        set_default();
        run_case("zero");
        chk("zero_const", pwm_duty_o, {16'd30000, 16'd30000, 16'd30000, 16'd30000});

        // Pitch P = +100, then yaw P = -50
        set_default(); pe[0] = 100;
        run_case("pitch_p");
        chk("pitch_p_const", pwm_duty_o, {16'd30100, 16'd30100, 16'd29900, 16'd29900});
        set_default(); pe[2] = -50;
        run_case("yaw_p");
        chk("yaw_p_const", pwm_duty_o, {16'd30050, 16'd29950, 16'd29950, 16'd30050});

        // Saturation both ways
        set_default(); base = 60000; pe[1] = 20000;
        run_case("sat_hi");
        chk("sat_hi_const", pwm_duty_o, {16'd50000, 16'd40000, 16'd50000, 16'd40000});
        chk("sat_hi_flags", 64'(sat_flags_o), 64'b1010);
        set_default(); base = 1000; pe[0] = 5000;
        run_case("sat_lo");
        chk("sat_lo_const", pwm_duty_o, {16'd6000, 16'd6000, 16'd0, 16'd0});
        chk("sat_lo_flags", 64'(sat_flags_o), 64'b0011);

        // Exactly on a limit: not flagged
        set_default(); base = 50000;
        run_case("at_max");
        chk("at_max_flags", 64'(sat_flags_o), 64'd0);

        // Gains and truncation
        set_default(); kp = 128; ki = 64; kd = 32; pe[0] = 3; ie[0] = 3; de[0] = 3;
        run_case("gains");
        chk("gains_d1", 64'(pwm_duty_o[15:0]), 64'd29998);
        set_default(); kp = 128; pe[0] = -1;
        run_case("floor");
        chk("floor_d1", 64'(pwm_duty_o[15:0]), 64'd30001);

        // Disarmed
        set_default(); pe[0] = 7000; base = 45000; arm = 1'b0;
        run_case("disarm");
        chk("disarm_const", pwm_duty_o, 64'd0);

        // Second start mid-run is ignored
        set_default(); pe[1] = 321; ie[2] = -900; ki = 100;
        model(ed, ef);
        @(posedge clk); #1;
        drive_case();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        ndone = 0; first = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) start_i = 1'b1;
            if (c == 6) start_i = 1'b0;
            @(posedge clk); #1;
            if (done_o) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        chk("restart_ndone", 64'(ndone), 64'd1);
        chk("restart_latency", 64'(first), 64'd11);
        chk("restart_duty", pwm_duty_o, ed);
        $display("run restart: dones=%0d first=%0d duty=%h", ndone, first, pwm_duty_o);

        // Reset during MAC aborts with no done and clears outputs
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done_o) ndone++;
        end
        chk("abort_ndone", 64'(ndone), 64'd0);
        chk("abort_duty", pwm_duty_o, 64'd0);
        chk("abort_flags", 64'(sat_flags_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        $display("run abort: dones=%0d duty=%h", ndone, pwm_duty_o);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            for (int a = 0; a < 3; a++) begin
                pe[a] = int'($urandom_range(0, 40000)) - 20000;
                ie[a] = int'($urandom_range(0, 40000)) - 20000;
                de[a] = int'($urandom_range(0, 40000)) - 20000;
            end
            kp   = int'($urandom_range(0, 600));
            ki   = int'($urandom_range(0, 300));
            kd   = int'($urandom_range(0, 300));
            base = int'($urandom_range(0, 65535));
            arm  = ($urandom_range(0, 7) != 0);
            run_case($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
